ahb_master_arbiter: RTL and testbench
=====================================

# ahb_master_arbiter

Round-robin bus arbiter that shares a single AHB address/data path between `NO_OF_MASTERS` requesting masters. It sits between the master agents' request/lock lines and the shared bus mux. It decides which master owns the bus, drives the `hmaster` ID carried in `ahbTransferCharStruct`, and never rearbitrates inside a fixed-length burst, an undefined-length burst or a locked sequence. An ERROR response aborts the current burst or lock and forces rearbitration.

## Interface
- `NO_OF_MASTERS`, 4: number of requesters (≥1).
- `HMASTER_WIDTH`, `(NO_OF_MASTERS==1) ? 1 : $clog2(NO_OF_MASTERS)`: master ID width.
- `hclk` in 1: clock. All logic is on the rising edge.
- `hreset` in 1: reset, synchronous and active-high.
- `hbusreq` in `NO_OF_MASTERS`: per-master bus request.
- `hlock` in `NO_OF_MASTERS`: per-master locked-sequence request.
- `htrans` in 2: transfer type on the shared bus (`ahbTransferEnum`).
- `hburst` in 3: burst type on the shared bus (`ahbBurstEnum`).
- `hready` in 1: combined transfer completion.
- `hresp` in 1: response (`ahbRespEnum`, 1 = ERROR).
- `hgrant` out `NO_OF_MASTERS`: one-hot grant, registered.
- `hmaster` out `HMASTER_WIDTH`: binary index of the granted master, registered.
- `hmastlock` out 1: high while the locked sequence is owned, registered.

## Operation
- State machine states:
  - `ARB`: arbitration open.
  - `FIXED`: WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16 in progress.
  - `UNDEF`: INCR in progress.
  - `LOCKED`: locked sequence in progress.
- All transitions are evaluated only at an edge with `hready=1`. With `hready=0`, state, counter, grant and pointer hold.
- Priority at an `hready=1` edge: `hresp=ERROR` first, then `hlock`, then burst start, then plain arbitration.
- **ERROR:** from any state → `ARB`, counter cleared, `hmastlock`→0, rearbitrate on the same edge.
- **ARB:**
  - If the owner has `hlock` & `hbusreq` → `LOCKED`, grant held.
  - Else if `htrans=NONSEQ` and `hburst` is fixed-length → `FIXED`, beat counter = beats−1 (3/7/15), grant held.
  - Else if `htrans=NONSEQ` & `hburst=INCR` → `UNDEF`, grant held.
  - Otherwise (IDLE, BUSY, NONSEQ SINGLE) → rearbitrate.
- **FIXED:** `htrans=SEQ` decrements the counter. When `SEQ` is accepted with counter=1, the last beat is done → `ARB` and rearbitrate on the same edge. `BUSY` and `IDLE` hold.
- **UNDEF:** `htrans=IDLE`, or `NONSEQ` with non-INCR `hburst`, → `ARB` and rearbitrate. `SEQ` and `BUSY` hold.
- **LOCKED:** `hmastlock=1`. When `hlock[owner]=0` → `ARB` and rearbitrate.
- **Rearbitration:**
  - Search `hbusreq` round-robin starting at (`hmaster`+1) mod `NO_OF_MASTERS` and wrapping, so the owner is checked last.
  - The first hit wins.
  - No requests → park on master 0.
  - The round-robin pointer is `hmaster` itself; there is no separate pointer state.
- `hmaster` always equals the encoding of `hgrant`. `hgrant` is always exactly one-hot.
- `NO_OF_MASTERS=1`: `hgrant=1` and `hmaster=0` permanently; lock and burst tracking still drive `hmastlock`.
- Counter width is 4 bits; the counter never underflows.

## Timing
- Reset (`hreset=1` at an edge):
  - `hgrant=1` (master 0), `hmaster=0`, `hmastlock=0`.
  - State `ARB`, counter 0.
  - Reset mid-burst or mid-lock discards all tracking immediately.
- The grant decision is made at edge N; `hgrant`/`hmaster`/`hmastlock` change after edge N (1-cycle latency). The new owner drives its address phase at edge N+1 if `hready=1`.
- The `LOCKED` entry edge registers `hmastlock=1` for the following cycle.
- The lock release edge registers `hmastlock=0` and the new grant together.
- Simultaneous ERROR and last beat: treated as ERROR; the result is identical (`ARB` plus rearbitrate).
- Requests asserted or dropped during `FIXED`, `UNDEF` or `LOCKED` have no effect until the exit edge.

## Test plan
- **Reset and park:** assert `hreset` for 2 cycles with `hbusreq=4'b1010`, then hold `hbusreq=0`. Required: during reset and after it, `hgrant=0001`, `hmaster=0`, `hmastlock=0`.
- **Round robin:** `hbusreq=4'b1011` held, `hready=1`, `htrans=NONSEQ SINGLE` every cycle. Required grant sequence: 1, 3, 0, 1, 3… (`hmaster` 1, 3, 0, 1, 3).
- **Fixed burst:** master 2 owns the bus and issues INCR4 (NONSEQ then 3×SEQ, one BUSY in between), with `hbusreq=4'b1111` throughout. Required: `hgrant=0100` until the 4th beat is accepted; the grant then moves to master 3 on the next cycle.
- **Wait states:** as the fixed-burst case, but with `hready=0` for 3 cycles on beat 2. Required: the counter and grant hold, and the burst still ends after exactly 4 accepted beats.
- **Lock:** master 1 is granted and raises `hlock[1]`, with master 0 requesting. Required: `hmastlock=1` from the next cycle; grant stays on master 1 for as long as `hlock[1]=1`; one cycle after `hlock[1]` drops, `hgrant=0001` and `hmastlock=0`.
- **ERROR abort:** during WRAP8 beat 3 by master 0, drive `hresp=ERROR` with `hready=1` while `hbusreq[2]=1`. Required: next cycle `hgrant=0100`, state `ARB`, counter 0.

Source files
------------

// File: rtl/ahb_master_arbiter_if.sv
// rtl/ahb_master_arbiter_if.sv - request/grant bundle between master agents and the bus arbiter
interface ahb_master_arbiter_if #(
   parameter int NO_OF_MASTERS = 4,
   parameter int HMASTER_WIDTH = (NO_OF_MASTERS == 1) ? 1 : $clog2(NO_OF_MASTERS)
);
   logic [NO_OF_MASTERS-1:0] hbusreq;
   logic [NO_OF_MASTERS-1:0] hlock;
   logic [1:0]               htrans;
   logic [2:0]               hburst;
   logic                     hready;
   logic                     hresp;
   logic [NO_OF_MASTERS-1:0] hgrant;
   logic [HMASTER_WIDTH-1:0] hmaster;
   logic                     hmastlock;

   modport master (
      output hbusreq, hlock, htrans, hburst, hready, hresp,
      input  hgrant, hmaster, hmastlock
   );

   modport slave (
      input  hbusreq, hlock, htrans, hburst, hready, hresp,
      output hgrant, hmaster, hmastlock
   );
endinterface

// File: rtl/ahb_master_arbiter.sv
// rtl/ahb_master_arbiter.sv - round-robin AHB bus arbiter with burst and lock tracking
module ahb_master_arbiter #(
   parameter int NO_OF_MASTERS = 4,
   parameter int HMASTER_WIDTH = (NO_OF_MASTERS == 1) ? 1 : $clog2(NO_OF_MASTERS)
) (
   input  logic                 hclk,
   input  logic                 hreset,
   ahb_master_arbiter_if.slave  bus
);
   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;
   localparam logic [2:0] BU_INCR   = 3'd1;

   typedef enum logic [1:0] {ARB, FIXED, UNDEF, LOCKED} state_t;

   state_t                   state;
   logic [3:0]               cnt;
   logic [HMASTER_WIDTH-1:0] next_owner;
   logic [HMASTER_WIDTH-1:0] cand;
   logic                     found;
   logic                     burst_fixed;
   logic [3:0]               burst_len_m1;

   // Search starts just past the current owner so the owner is checked last.
   always_comb begin
      next_owner = '0;
      cand       = '0;
      found      = 1'b0;
      for (int i = 1; i <= NO_OF_MASTERS; i++) begin
         cand = HMASTER_WIDTH'((int'(bus.hmaster) + i) % NO_OF_MASTERS);
         if (!found && bus.hbusreq[cand]) begin
            next_owner = cand;
            found      = 1'b1;
         end
      end
   end

   always_comb begin
      burst_fixed  = (bus.hburst[2:1] != 2'b00);
      burst_len_m1 = 4'd3;
      case (bus.hburst[2:1])
         2'b10:   burst_len_m1 = 4'd7;
         2'b11:   burst_len_m1 = 4'd15;
         default: burst_len_m1 = 4'd3;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state         <= ARB;
         cnt           <= 4'd0;
         bus.hgrant    <= NO_OF_MASTERS'(1);
         bus.hmaster   <= '0;
         bus.hmastlock <= 1'b0;
      end else if (bus.hready) begin
         if (bus.hresp) begin
            state         <= ARB;
            cnt           <= 4'd0;
            bus.hmastlock <= 1'b0;
            bus.hgrant    <= NO_OF_MASTERS'(1) << next_owner;
            bus.hmaster   <= next_owner;
         end else begin
            case (state)
               ARB: begin
                  if (bus.hlock[bus.hmaster] && bus.hbusreq[bus.hmaster]) begin
                     state         <= LOCKED;
                     bus.hmastlock <= 1'b1;
                  end else if (bus.htrans == TR_NONSEQ && burst_fixed) begin
                     state <= FIXED;
                     cnt   <= burst_len_m1;
                  end else if (bus.htrans == TR_NONSEQ && bus.hburst == BU_INCR) begin
                     state <= UNDEF;
                  end else begin
                     bus.hgrant  <= NO_OF_MASTERS'(1) << next_owner;
                     bus.hmaster <= next_owner;
                  end
               end
               FIXED: begin
                  if (bus.htrans == TR_SEQ) begin
                     if (cnt <= 4'd1) begin
                        state       <= ARB;
                        cnt         <= 4'd0;
                        bus.hgrant  <= NO_OF_MASTERS'(1) << next_owner;
                        bus.hmaster <= next_owner;
                     end else begin
                        cnt <= cnt - 4'd1;
                     end
                  end
               end
               UNDEF: begin
                  if (bus.htrans == TR_IDLE ||
                      (bus.htrans == TR_NONSEQ && bus.hburst != BU_INCR)) begin
                     state       <= ARB;
                     bus.hgrant  <= NO_OF_MASTERS'(1) << next_owner;
                     bus.hmaster <= next_owner;
                  end
               end
               LOCKED: begin
                  if (!bus.hlock[bus.hmaster]) begin
                     state         <= ARB;
                     bus.hmastlock <= 1'b0;
                     bus.hgrant    <= NO_OF_MASTERS'(1) << next_owner;
                     bus.hmaster   <= next_owner;
                  end
               end
               default: state <= ARB;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb/tb_ahb_master_arbiter.sv - directed-vector bench for ahb_master_arbiter
module tb_ahb_master_arbiter;
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [1:0] NONSEQ = 2'd2;
   localparam logic [1:0] SEQ    = 2'd3;
   localparam logic [2:0] SINGLE = 3'd0;
   localparam logic [2:0] INCR   = 3'd1;
   localparam logic [2:0] INCR4  = 3'd3;
   localparam logic [2:0] WRAP8  = 3'd4;

   logic hclk;
   logic hreset;
   int   errors;
   int   checks;

   ahb_master_arbiter_if #(.NO_OF_MASTERS(4)) bus ();

   ahb_master_arbiter #(.NO_OF_MASTERS(4)) dut (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic expect_owner(input string tag, input int m, input logic lk);
      check({tag, ".hgrant"}, 32'(bus.hgrant), 32'(4'b0001 << m));
      check({tag, ".hmaster"}, 32'(bus.hmaster), 32'(m));
      check({tag, ".hmastlock"}, 32'(bus.hmastlock), 32'(lk));
   endtask

   int rr_exp[5] = '{1, 3, 0, 1, 3};

   initial begin
      errors = 0;
      checks = 0;
      hreset      = 1'b1;
      bus.hbusreq = 4'b1010;
      bus.hlock   = 4'b0000;
      bus.htrans  = IDLE;
      bus.hburst  = SINGLE;
      bus.hready  = 1'b1;
      bus.hresp   = 1'b0;

      // reset and park
      tick();
      expect_owner("reset1", 0, 1'b0);
      tick();
      expect_owner("reset2", 0, 1'b0);
      hreset      = 1'b0;
      bus.hbusreq = 4'b0000;
      tick();
      expect_owner("park", 0, 1'b0);
      tick();
      expect_owner("park2", 0, 1'b0);

      // round robin with single transfers
      bus.hbusreq = 4'b1011;
      bus.htrans  = NONSEQ;
      bus.hburst  = SINGLE;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_owner($sformatf("rr%0d", i), rr_exp[i], 1'b0);
      end

      // fixed INCR4 by master 2 with a BUSY inserted
      bus.hbusreq = 4'b0100;
      bus.htrans  = IDLE;
      tick();
      expect_owner("fx_own", 2, 1'b0);
      bus.hbusreq = 4'b1111;
      bus.htrans  = NONSEQ;
      bus.hburst  = INCR4;
      tick();
      expect_owner("fx_b1", 2, 1'b0);
      check("fx_cnt1", 32'(dut.cnt), 32'd3);
      bus.htrans = SEQ;
      tick();
      expect_owner("fx_b2", 2, 1'b0);
      check("fx_cnt2", 32'(dut.cnt), 32'd2);
      bus.htrans = BUSY;
      tick();
      expect_owner("fx_busy", 2, 1'b0);
      check("fx_cntb", 32'(dut.cnt), 32'd2);
      bus.htrans = SEQ;
      tick();
      expect_owner("fx_b3", 2, 1'b0);
      check("fx_cnt3", 32'(dut.cnt), 32'd1);
      tick();
      expect_owner("fx_end", 3, 1'b0);
      check("fx_cnt4", 32'(dut.cnt), 32'd0);

      // fixed INCR4 with three wait states on beat 2
      bus.hbusreq = 4'b0100;
      bus.htrans  = IDLE;
      tick();
      expect_owner("ws_own", 2, 1'b0);
      bus.hbusreq = 4'b1111;
      bus.htrans  = NONSEQ;
      tick();
      check("ws_cnt1", 32'(dut.cnt), 32'd3);
      bus.htrans = SEQ;
      bus.hready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_owner($sformatf("ws_wait%0d", i), 2, 1'b0);
         check($sformatf("ws_cntw%0d", i), 32'(dut.cnt), 32'd3);
      end
      bus.hready = 1'b1;
      tick();
      check("ws_cnt2", 32'(dut.cnt), 32'd2);
      tick();
      expect_owner("ws_b3", 2, 1'b0);
      tick();
      expect_owner("ws_end", 3, 1'b0);

      // undefined-length INCR holds through SEQ/BUSY, releases on IDLE
      bus.hbusreq = 4'b0100;
      bus.htrans  = IDLE;
      tick();
      bus.hbusreq = 4'b1111;
      bus.htrans  = NONSEQ;
      bus.hburst  = INCR;
      tick();
      expect_owner("ud_start", 2, 1'b0);
      bus.htrans = SEQ;
      tick();
      expect_owner("ud_seq", 2, 1'b0);
      bus.htrans = BUSY;
      tick();
      expect_owner("ud_busy", 2, 1'b0);
      bus.htrans = IDLE;
      tick();
      expect_owner("ud_end", 3, 1'b0);

      // locked sequence by master 1 while master 0 requests
      bus.hbusreq = 4'b0010;
      tick();
      expect_owner("lk_own", 1, 1'b0);
      bus.hbusreq = 4'b0011;
      bus.hlock   = 4'b0010;
      bus.htrans  = NONSEQ;
      bus.hburst  = SINGLE;
      tick();
      expect_owner("lk_enter", 1, 1'b1);
      bus.hburst = INCR4;
      tick();
      expect_owner("lk_hold1", 1, 1'b1);
      bus.hbusreq = 4'b1101;
      tick();
      expect_owner("lk_hold2", 1, 1'b1);
      bus.hbusreq = 4'b0011;
      bus.hlock   = 4'b0000;
      bus.htrans  = IDLE;
      tick();
      expect_owner("lk_release", 0, 1'b0);
      check("lk_state", 32'(dut.state), 32'd0);

      // ERROR on WRAP8 beat 3 by master 0
      bus.hbusreq = 4'b0101;
      bus.htrans  = NONSEQ;
      bus.hburst  = WRAP8;
      tick();
      expect_owner("er_b1", 0, 1'b0);
      check("er_cnt1", 32'(dut.cnt), 32'd7);
      bus.htrans = SEQ;
      tick();
      check("er_cnt2", 32'(dut.cnt), 32'd6);
      bus.hresp = 1'b1;
      tick();
      bus.hresp = 1'b0;
      expect_owner("er_abort", 2, 1'b0);
      check("er_state", 32'(dut.state), 32'd0);
      check("er_cnt", 32'(dut.cnt), 32'd0);

      // reset in the middle of a lock discards it
      bus.hbusreq = 4'b0100;
      bus.hlock   = 4'b0100;
      tick();
      expect_owner("rl_lock", 2, 1'b1);
      hreset = 1'b1;
      tick();
      expect_owner("rl_reset", 0, 1'b0);
      check("rl_state", 32'(dut.state), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
